sign_magnitude_subtractor_seq: RTL and testbench



---
 rtl/sign_magnitude_subtractor_seq.sv | 170 +++++++++++++++++
 tb/tb_sign_magnitude_subtractor_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sign_magnitude_subtractor_seq.sv
// sign_magnitude_subtractor_seq
//
// Bit-serial subtractor for N-bit sign-magnitude operands: diff = a - b.
// The MSB is the sign and the low N-1 bits are the magnitude. It uses the
// same number format as the combinational sign-magnitude adder, but
// processes one magnitude bit per clock under a start/done handshake.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   start      request; only sampled while ready is high
//   a, b       minuend / subtrahend, captured on the accepting edge
//   ready      high only while idle
//   done_tick  one-cycle pulse; diff/overflow carry the new result
//   diff       registered result, held until the next completion
//   overflow   registered magnitude carry-out of an effective add
//
// Optional build macro:
//   SM_SUB_SAT_EN  when defined, an overflowing magnitude saturates to all
//                  ones with the sign kept; otherwise it wraps modulo 2^M.

module sign_magnitude_subtractor_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ready,
  output logic         done_tick,
  output logic [N-1:0] diff,
  output logic         overflow
);

  localparam int M  = N - 1;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state;
  logic [M-1:0]   max_r;
  logic [M-1:0]   min_r;
  logic [M-1:0]   res_r;
  logic           sign_r;
  logic           op_add_r;
  logic           carry_r;
  logic [CW-1:0]  cnt_r;

  // Operand decode for the accepting edge. Subtraction is turned into an
  // addition of -b, so only b's sign is flipped.
  logic [M-1:0]   ma;
  logic [M-1:0]   mb;
  logic           sa;
  logic           sb_eff;
  logic           a_gt_b;

  assign sa     = a[N-1];
  assign ma     = a[M-1:0];
  assign sb_eff = ~b[N-1];
  assign mb     = b[M-1:0];
  assign a_gt_b = (ma > mb);

  // One serial bit slice. The sum and difference bits share the same XOR;
  // only the carry/borrow out differs between the two operations.
  logic           bit_x;
  logic           bit_y;
  logic           sum_bit;
  logic           carry_add;
  logic           borrow_sub;
  logic           carry_next;
  logic [M:0]     res_cat;
  logic [M-1:0]   res_next;

  assign bit_x      = max_r[0];
  assign bit_y      = min_r[0];
  assign sum_bit    = bit_x ^ bit_y ^ carry_r;
  assign carry_add  = (bit_x & bit_y) | (carry_r & (bit_x ^ bit_y));
  assign borrow_sub = (~bit_x & bit_y) | (carry_r & ~(bit_x ^ bit_y));
  assign carry_next = op_add_r ? carry_add : borrow_sub;

  // Result bits enter from the MSB side so that after M shifts the LSB
  // produced first has landed in bit 0.
  assign res_cat  = {sum_bit, res_r};
  assign res_next = res_cat[M:1];

  // Final-edge result. Subtraction never borrows out because the larger
  // magnitude is always the minuend, so overflow only exists for adds.
  logic           ovf_final;
  logic [M-1:0]   mag_final;
  logic           sign_final;

  assign ovf_final = op_add_r & carry_add;

`ifdef SM_SUB_SAT_EN
  assign mag_final = ovf_final ? {M{1'b1}} : res_next;
`else
  assign mag_final = res_next;
`endif

  // A zero magnitude is always reported as +0.
  assign sign_final = sign_r & (mag_final != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      max_r     <= '0;
      min_r     <= '0;
      res_r     <= '0;
      sign_r    <= 1'b0;
      op_add_r  <= 1'b0;
      carry_r   <= 1'b0;
      cnt_r     <= '0;
      ready     <= 1'b1;
      done_tick <= 1'b0;
      diff      <= '0;
      overflow  <= 1'b0;
    end else begin
      done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Order the magnitudes so the serial subtract never borrows out;
            // on a tie the subtrahend side supplies the sign.
            if (a_gt_b) begin
              max_r  <= ma;
              min_r  <= mb;
              sign_r <= sa;
            end else begin
              max_r  <= mb;
              min_r  <= ma;
              sign_r <= sb_eff;
            end
            op_add_r <= (sa == sb_eff);
            carry_r  <= 1'b0;
            res_r    <= '0;
            cnt_r    <= CW'(M - 1);
            ready    <= 1'b0;
            state    <= CALC;
          end
        end

        CALC: begin
          max_r   <= max_r >> 1;
          min_r   <= min_r >> 1;
          carry_r <= carry_next;
          res_r   <= res_next;
          cnt_r   <= cnt_r - CW'(1);
          if (cnt_r == '0) begin
            diff      <= {sign_final, mag_final};
            overflow  <= ovf_final;
            done_tick <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end

        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sign_magnitude_subtractor_seq.sv
// tb_sign_magnitude_subtractor_seq
//
// Self-checking bench for sign_magnitude_subtractor_seq (N = 4). Expected
// results are computed arithmetically when an operation is accepted, queued,
// and compared together with the completion latency on each done_tick.

module tb_sign_magnitude_subtractor_seq;

  localparam int N = 4;
  localparam int M = N - 1;

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ready;
  logic         done_tick;
  logic [N-1:0] diff;
  logic         overflow;

  sign_magnitude_subtractor_seq #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .done_tick (done_tick),
    .diff      (diff),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N:0] exp;
    int         cyc0;
  } entry_t;

  entry_t exp_q[$];
  int     tests_run    = 0;
  int     tests_failed = 0;
  int     cyc          = 0;
  int     accepts      = 0;

  // Reference: ordinary integer arithmetic on the decoded signed values.
  function automatic logic [N:0] model(input logic [N-1:0] av, input logic [N-1:0] bv);
    logic         s_a;
    logic         s_b;
    logic [M-1:0] m_a;
    logic [M-1:0] m_b;
    logic [M:0]   sum;
    logic [M-1:0] mag;
    logic         sgn;
    logic         ovf;
    s_a = av[N-1];
    s_b = ~bv[N-1];
    m_a = av[M-1:0];
    m_b = bv[M-1:0];
    ovf = 1'b0;
    if (s_a == s_b) begin
      sum = {1'b0, m_a} + {1'b0, m_b};
      mag = sum[M-1:0];
      ovf = sum[M];
      sgn = s_a;
    end else if (m_a >= m_b) begin
      mag = m_a - m_b;
      sgn = s_a;
    end else begin
      mag = m_b - m_a;
      sgn = s_b;
    end
`ifdef SM_SUB_SAT_EN
    if (ovf) mag = {M{1'b1}};
`endif
    if (mag == '0) sgn = 1'b0;
    return {ovf, sgn, mag};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Acceptance monitor: pre-edge values are read here, so this sees exactly
  // what the DUT samples on this edge.
  always @(posedge clk) begin
    if (!reset && ready && start) begin
      exp_q.push_back('{exp: model(a, b), cyc0: cyc});
      accepts++;
    end
    cyc++;
  end

  // Completion monitor.
  always @(negedge clk) begin
    if (done_tick) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 32'(done_tick), 32'd0);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        checkOutput("diff",     32'(diff),       32'(e.exp[N-1:0]));
        checkOutput("overflow", 32'(overflow),   32'(e.exp[N]));
        checkOutput("latency",  32'(cyc - e.cyc0), 32'(N));
      end
    end
  end

  // Drive one request in the next cycle the DUT is ready; returns one cycle
  // later with start dropped.
  task automatic applyStimulus(input logic [N-1:0] av, input logic [N-1:0] bv);
    int guard;
    guard = 0;
    while (!ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) checkOutput("ready_timeout", 32'(ready), 32'd1);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || !ready) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready",    32'(ready),     32'd1);
    checkOutput("rst_done",     32'(done_tick), 32'd0);
    checkOutput("rst_diff",     32'(diff),      32'd0);
    checkOutput("rst_overflow", 32'(overflow),  32'd0);
    reset = 1'b0;
    @(negedge clk);

    // +3 - +1: also check ready stays low for the whole operation.
    applyStimulus(4'b0_011, 4'b0_001);
    for (int i = 1; i <= N; i++) begin
      checkOutput("ready_busy", 32'(ready), 32'd0);
      @(negedge clk);
    end
    checkOutput("ready_back", 32'(ready), 32'd1);
    waitDrain();

    applyStimulus(4'b0_001, 4'b0_101);
    applyStimulus(4'b0_110, 4'b1_011);
    applyStimulus(4'b1_010, 4'b1_010);
    applyStimulus(4'b0_000, 4'b0_000);
    applyStimulus(4'b1_111, 4'b0_111);
    applyStimulus(4'b0_111, 4'b1_001);
    applyStimulus(4'b1_100, 4'b0_100);
    waitDrain();

    // Reset in cycle 2 of an operation aborts it immediately.
    applyStimulus(4'b0_111, 4'b0_001);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("abort_ready",    32'(ready),    32'd1);
    checkOutput("abort_diff",     32'(diff),     32'd0);
    checkOutput("abort_overflow", 32'(overflow), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (N + 2) @(negedge clk);
    applyStimulus(4'b0_101, 4'b0_010);
    waitDrain();

    // Start held high across a full operation with operands changing after
    // acceptance: exactly two operations are accepted, back to back.
    accepts = 0;
    a     = 4'b0_010;
    b     = 4'b1_011;
    start = 1'b1;
    @(negedge clk);
    a = 4'b1_110;
    b = 4'b0_001;
    repeat (N + 1) @(negedge clk);
    start = 1'b0;
    waitDrain();
    checkOutput("held_accepts", 32'(accepts), 32'd2);

    // Random back-to-back traffic.
    for (int i = 0; i < 24; i++) begin
      applyStimulus(N'($urandom_range(0, (1 << N) - 1)), N'($urandom_range(0, (1 << N) - 1)));
    end
    waitDrain();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
